pe_out_collector: RTL and testbench

Output collector that sits directly downstream of a row of `sub_pe` accumulators. It captures each lane's finished 16-bit partial sum on that lane's `done` pulse and serialises pending lanes through a lowest-index-first arbiter. Each result is requantised (bias add, ReLU, right shift, saturate to 8 bits) and queued in a first-word-fall-through FIFO, which the write-back stage drains via a valid/ready handshake.

---
 rtl/pe_out_collector.sv | 204 ++++++++++++++++++++
 tb/tb_pe_out_collector.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_out_collector.sv
// Output collector for a row of PE accumulators. Each lane's result is captured, arbitrated
// lowest-index-first, requantised to 8 bits and queued in a FWFT FIFO. Optional macro
// PE_COLLECT_ROUND_EN selects round-half-up requantisation instead of truncation.
module pe_out_collector #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LANES-1:0]    in_done,
    input  logic [16*LANES-1:0] in_value,
    input  logic [15:0]         bias,
    input  logic [3:0]          shift,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic [LW-1:0]       out_lane,
    output logic                ovf
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Per-lane capture state
    logic [LANES-1:0] arm_q;
    logic [LANES-1:0] pend_q, pend_d;
    logic [15:0]      hold_q [LANES];
    logic             ovf_q, ovf_d;

    // Arbiter
    logic             grant_vld;
    logic [LW-1:0]    grant_idx;
    logic [CW+1:0]    in_flight;
    logic             credit_ok;
    logic             issue;
    logic [LANES-1:0] issue_vec;

    // Requantisation pipeline
    logic signed [17:0] s1_sum_d;
    logic               s1_v_q;
    logic signed [17:0] s1_sum_q;
    logic [3:0]         s1_shift_q;
    logic [LW-1:0]      s1_lane_q;
    logic [18:0]        s2_ext;
    logic [18:0]        s2_shifted;
    logic [7:0]         s2_data_d;
    logic               s2_v_q;
    logic [7:0]         s2_data_q;
    logic [LW-1:0]      s2_lane_q;

    // Output FIFO
    logic [7:0]    mem_data [DEPTH];
    logic [LW-1:0] mem_lane [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop;

    // in_value is only final one cycle after in_done, so done is delayed by one stage
    always_ff @(posedge clk) begin
        if (reset) begin
            arm_q <= '0;
        end else begin
            arm_q <= in_done;
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                grant_vld = 1'b1;
                grant_idx = LW'(i);
            end
        end
    end

    // Credit covers everything that will eventually land in the FIFO, so it never overflows
    assign in_flight = {2'b00, count_q} + (CW+2)'(s1_v_q) + (CW+2)'(s2_v_q);
    assign credit_ok = in_flight < (CW+2)'(DEPTH);
    assign issue     = grant_vld & credit_ok;

    always_comb begin
        issue_vec = '0;
        if (issue) begin
            issue_vec[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        pend_d = pend_q & ~issue_vec;
        ovf_d  = ovf_q;
        for (int i = 0; i < LANES; i++) begin
            if (arm_q[i]) begin
                if (pend_q[i] && !issue_vec[i]) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    // A lane issued this cycle frees its holding register for the incoming value
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (arm_q[i] && (!pend_q[i] || issue_vec[i])) begin
                hold_q[i] <= in_value[16*i +: 16];
            end
        end
    end

    assign s1_sum_d = $signed({2'b00, hold_q[grant_idx]}) + $signed({{2{bias[15]}}, bias});

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q     <= 1'b0;
            s1_sum_q   <= '0;
            s1_shift_q <= '0;
            s1_lane_q  <= '0;
        end else begin
            s1_v_q <= issue;
            if (issue) begin
                s1_sum_q   <= s1_sum_d;
                s1_shift_q <= shift;
                s1_lane_q  <= grant_idx;
            end
        end
    end

    // Negative sums are forced to zero, so only the non-negative path needs shifting
    always_comb begin
        s2_ext = {s1_sum_q[17], s1_sum_q};
`ifdef PE_COLLECT_ROUND_EN
        if (s1_shift_q != 4'd0) begin
            s2_ext = s2_ext + (19'd1 << (s1_shift_q - 4'd1));
        end
`endif
        s2_shifted = s2_ext >> s1_shift_q;
        if (s1_sum_q[17]) begin
            s2_data_d = 8'd0;
        end else if (|s2_shifted[18:8]) begin
            s2_data_d = 8'hff;
        end else begin
            s2_data_d = s2_shifted[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_lane_q <= '0;
        end else begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_data_q <= s2_data_d;
                s2_lane_q <= s1_lane_q;
            end
        end
    end

    assign push = s2_v_q;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= s2_data_q;
            mem_lane[wr_ptr_q] <= s2_lane_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_data[rd_ptr_q] : 8'd0;
    assign out_lane  = out_valid ? mem_lane[rd_ptr_q] : '0;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pe_out_collector.sv
// Bench for pe_out_collector: directed table vectors, hand sequences for ordering, overflow
// and reset, then random traffic checked every cycle against a queue-based reference model.
module tb_pe_out_collector;
    localparam int LANES = 4;
    localparam int DEPTH = 8;
    localparam int LW    = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [LANES-1:0]    in_done;
    logic [16*LANES-1:0] in_value;
    logic [15:0]         bias;
    logic [3:0]          shift;
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          out_data;
    logic [LW-1:0]       out_lane;
    logic                ovf;

    always #5 clk = ~clk;

    pe_out_collector #(
        .LANES (LANES),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_done   (in_done),
        .in_value  (in_value),
        .bias      (bias),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .ovf       (ovf)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: results as transactions moving through queues
    typedef struct { int data; int lane; } item_t;
    typedef struct { int data; int lane; int due; } pipe_t;
    item_t m_fifo[$];
    pipe_t m_pipe[$];
    bit    m_arm  [LANES];
    bit    m_pend [LANES];
    int    m_hold [LANES];
    bit    m_ovf;
    int    edge_n = 0;

    function automatic int requant(int value, int b, int sh);
        int s;
        int r;
        s = value + b;
        if (s < 0) return 0;
`ifdef PE_COLLECT_ROUND_EN
        if (sh != 0) s = s + (1 << (sh - 1));
`endif
        r = s >> sh;
        return (r > 255) ? 255 : r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advances the model by one clock edge using the inputs the DUT samples at that edge
    task automatic model_step();
        int    n;
        int    grant;
        bit    credit;
        pipe_t p;
        item_t it;
        n = edge_n;
        edge_n++;
        if (reset) begin
            m_fifo.delete();
            m_pipe.delete();
            m_ovf = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                m_arm[i]  = 1'b0;
                m_pend[i] = 1'b0;
            end
            return;
        end
        grant  = -1;
        credit = (m_fifo.size() + m_pipe.size()) < DEPTH;
        if (credit) begin
            for (int i = LANES - 1; i >= 0; i--) if (m_pend[i]) grant = i;
        end
        if (m_fifo.size() > 0 && out_ready) void'(m_fifo.pop_front());
        while (m_pipe.size() > 0 && m_pipe[0].due == n) begin
            it.data = m_pipe[0].data;
            it.lane = m_pipe[0].lane;
            m_fifo.push_back(it);
            void'(m_pipe.pop_front());
        end
        if (grant >= 0) begin
            p.data = requant(m_hold[grant], int'($signed(bias)), int'(shift));
            p.lane = grant;
            p.due  = n + 2;
            m_pipe.push_back(p);
            m_pend[grant] = 1'b0;
        end
        for (int i = 0; i < LANES; i++) begin
            if (m_arm[i]) begin
                if (m_pend[i]) begin
                    m_ovf = 1'b1;
                end else begin
                    m_hold[i] = int'(in_value[16*i +: 16]);
                    m_pend[i] = 1'b1;
                end
            end
            m_arm[i] = in_done[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_out_valid", out_valid, (m_fifo.size() > 0) ? 1 : 0);
        check("model_out_data", out_data, (m_fifo.size() > 0) ? m_fifo[0].data : 0);
        check("model_out_lane", out_lane, (m_fifo.size() > 0) ? m_fifo[0].lane : 0);
        check("model_ovf", ovf, m_ovf);
    endtask

    typedef struct { int value; int b; int sh; int exp; } vec_t;
    vec_t tbl[6];

    initial begin
        int lat;
        int cnt;
        int l0;
        int l0data;
        int bv;

        tbl[0] = '{400, -16, 2, 96};
`ifdef PE_COLLECT_ROUND_EN
        tbl[1] = '{390, 0, 2, 98};
`else
        tbl[1] = '{390, 0, 2, 97};
`endif
        tbl[2] = '{65535, 0, 0, 255};
        tbl[3] = '{10, -20, 0, 0};
        tbl[4] = '{1000, 24, 3, 128};
        tbl[5] = '{200, -300, 5, 0};

        reset = 1'b1; in_done = '0; in_value = '0; bias = '0; shift = '0; out_ready = 1'b1;
        tick();
        tick();
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_lane", out_lane, 0);
        check("reset_ovf", ovf, 0);
        reset = 1'b0;
        tick();

        // Single-lane requantisation vectors, with latency and hold-under-backpressure
        foreach (tbl[k]) begin
            out_ready = 1'b0;
            bias  = 16'(tbl[k].b);
            shift = 4'(tbl[k].sh);
            in_done = 4'b0001;
            tick();
            in_done = '0;
            in_value[15:0] = 16'(tbl[k].value);
            lat = 0;
            do begin
                tick();
                lat++;
            end while (!out_valid && lat < 12);
            check("vec_latency", lat, 4);
            check("vec_data", out_data, tbl[k].exp);
            check("vec_lane", out_lane, 0);
            tick();
            tick();
            check("vec_stable_data", out_data, tbl[k].exp);
            out_ready = 1'b1;
            tick();
            check("vec_popped", out_valid, 0);
        end

        // All lanes done together: results leave in lane order on consecutive cycles
        bias = '0; shift = '0; out_ready = 1'b1;
        in_done = 4'b1111;
        tick();
        in_done = '0;
        in_value = {16'd4, 16'd3, 16'd2, 16'd1};
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 12);
        for (int k = 0; k < 4; k++) begin
            check("order_lane", out_lane, k);
            check("order_data", out_data, k + 1);
            tick();
        end
        tick();

        // Fill FIFO under backpressure, then overrun lane 0
        out_ready = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            in_done = 4'b0010;
            tick();
            in_done = '0;
            in_value[31:16] = 16'(10 + j);
            tick();
        end
        tick();
        tick();
        in_done = 4'b0001;
        tick();
        in_done = '0;
        in_value[15:0] = 16'd5;
        tick();
        tick();
        check("ovf_before_drop", ovf, 0);
        in_done = 4'b0001;
        tick();
        in_done = '0;
        in_value[15:0] = 16'd7;
        tick();
        check("ovf_after_drop", ovf, 1);
        out_ready = 1'b1;
        cnt = 0; l0 = 0; l0data = -1;
        for (int t = 0; t < 40; t++) begin
            if (out_valid) begin
                cnt++;
                if (out_lane == 0) begin
                    l0++;
                    l0data = int'(out_data);
                end
            end
            tick();
        end
        check("drain_total", cnt, DEPTH + 1);
        check("drain_lane0_count", l0, 1);
        check("drain_lane0_data", l0data, 5);
        check("ovf_sticky", ovf, 1);

        // Reset with results queued and in flight
        out_ready = 1'b0;
        in_done = 4'b0111;
        tick();
        in_done = '0;
        in_value = {16'd0, 16'd3, 16'd2, 16'd1};
        tick();
        in_done = 4'b1001;
        tick();
        in_done = '0;
        in_value = {16'd4, 16'd0, 16'd0, 16'd9};
        tick();
        tick();
        tick();
        check("pre_reset_valid", out_valid, 1);
        reset = 1'b1;
        in_done = 4'b1111;
        tick();
        reset = 1'b0;
        in_done = '0;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_out_data", out_data, 0);
        check("midreset_out_lane", out_lane, 0);
        check("midreset_ovf", ovf, 0);
        out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            check("no_stale_entry", out_valid, 0);
        end

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < LANES; i++) in_done[i] = ($urandom_range(0, 3) == 0);
            in_value = {$urandom, $urandom};
            bv = int'($urandom_range(0, 1023)) - 512;
            bias = 16'(bv);
            shift = 4'($urandom_range(0, 10));
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
